// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared types for the serial ALU.
//   alu_op_e    - opcode encoding (ADD, SUB, AND, OR)
//   alu_state_e - control FSM states
//   maj3        - 3-input majority, the full-adder carry
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpOr  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } alu_state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice.
//   a, b       - operand bits
//   ainv, binv - operand inversion, applied to logic ops only
//   cin        - carry in (already complemented by the caller for SUB)
//   op         - operation
//   res        - result bit
//   cout       - carry out (0 for logic ops)
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    ainv,
  input  logic    binv,
  input  logic    cin,
  input  alu_op_e op,
  output logic    res,
  output logic    cout
);

  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    unique case (op)
      OpAdd: begin
        res  = a ^ b ^ cin;
        cout = maj3(a, b, cin);
      end
      // Subtraction is A + ~B + carry; the inverts do not apply.
      OpSub: begin
        res  = a ^ ~b ^ cin;
        cout = maj3(a, ~b, cin);
      end
      OpAnd: res = (a ^ ainv) & (b ^ binv);
      OpOr:  res = (a ^ ainv) | (b ^ binv);
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// serial_alu: multi-cycle WIDTH-bit ALU, SLICES bits per clock, LSB chunk first.
//   clk, reset (sync, active-high)
//   start, a, b, op, ainvert, binvert, carry_in - request, latched when accepted
//   busy   - high while the chunks are being processed
//   done   - one-cycle pulse, result and flags valid
//   result, carry_out, overflow, zero, greater - held until the next accepted start
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SLICES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             greater
);

  if (WIDTH < 2 || SLICES == 0 || (WIDTH % SLICES) != 0) begin : g_param_check
    $error("serial_alu: WIDTH must be >= 2 and an integer multiple of SLICES");
  end

  localparam int unsigned NChunks = WIDTH / SLICES;
  localparam int unsigned CntW    = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NChunks - 1);

  alu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Operands shift right each cycle so the current chunk always sits in the low bits.
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  alu_op_e          op_q, op_d;
  logic             ainv_q, ainv_d, binv_q, binv_d;
  logic             carry_q, carry_d;
  logic             gt_q, gt_d;
  logic             nz_q, nz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             greater_q, greater_d;

  logic [SLICES:0]          chain;
  logic [SLICES-1:0]        chunk_res;
  logic [WIDTH+SLICES-1:0]  res_cat;
  logic                     gt_chunk;
  logic                     is_arith;

  assign chain[0] = carry_q;

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a    (a_sh_q[i]),
      .b    (b_sh_q[i]),
      .ainv (ainv_q),
      .binv (binv_q),
      .cin  (chain[i]),
      .op   (op_q),
      .res  (chunk_res[i]),
      .cout (chain[i+1])
    );
  end

  // New chunk enters at the top; after NChunks shifts the word is in place.
  assign res_cat  = {chunk_res, res_sh_q};
  assign is_arith = (op_q == OpAdd) || (op_q == OpSub);

  // Higher bits override lower ones whenever the operand bits differ.
  always_comb begin
    gt_chunk = gt_q;
    for (int i = 0; i < int'(SLICES); i++) begin
      if (a_sh_q[i] != b_sh_q[i]) gt_chunk = a_sh_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    op_d        = op_q;
    ainv_d      = ainv_q;
    binv_d      = binv_q;
    carry_d     = carry_q;
    gt_d        = gt_q;
    nz_d        = nz_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    greater_d   = greater_q;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = alu_op_e'(op);
          ainv_d  = ainvert;
          binv_d  = binvert;
          // SUB is A + ~B + ~borrow_in.
          carry_d = (alu_op_e'(op) == OpSub) ? ~carry_in : carry_in;
          gt_d    = 1'b0;
          nz_d    = 1'b0;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> SLICES;
        b_sh_d   = b_sh_q >> SLICES;
        res_sh_d = res_cat[WIDTH+SLICES-1:SLICES];
        carry_d  = chain[SLICES];
        gt_d     = gt_chunk;
        nz_d     = nz_q | (|chunk_res);
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          result_d    = res_cat[WIDTH+SLICES-1:SLICES];
          carry_out_d = is_arith & chain[SLICES];
          overflow_d  = is_arith & (chain[SLICES] ^ chain[SLICES-1]);
          zero_d      = ~nz_d;
          greater_d   = gt_chunk;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      op_q        <= OpAdd;
      ainv_q      <= 1'b0;
      binv_q      <= 1'b0;
      carry_q     <= 1'b0;
      gt_q        <= 1'b0;
      nz_q        <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      op_q        <= op_d;
      ainv_q      <= ainv_d;
      binv_q      <= binv_d;
      carry_q     <= carry_d;
      gt_q        <= gt_d;
      nz_q        <= nz_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      greater_q   <= greater_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign greater   = greater_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: drives two serial_alu instances (SLICES=1 and SLICES=4, WIDTH=8) with the
// same requests and compares both against an arithmetic reference model.
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       ainvert, binvert, carry_in;

  logic       busy1, done1, cout1, ovf1, zero1, gt1;
  logic [7:0] result1;
  logic       busy4, done4, cout4, ovf4, zero4, gt4;
  logic [7:0] result4;
  logic [11:0] obs1, obs4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(8), .SLICES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .ainvert(ainvert), .binvert(binvert), .carry_in(carry_in),
    .busy(busy1), .done(done1), .result(result1), .carry_out(cout1),
    .overflow(ovf1), .zero(zero1), .greater(gt1)
  );

  serial_alu #(.WIDTH(8), .SLICES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .ainvert(ainvert), .binvert(binvert), .carry_in(carry_in),
    .busy(busy4), .done(done4), .result(result4), .carry_out(cout4),
    .overflow(ovf4), .zero(zero4), .greater(gt4)
  );

  // {greater, zero, overflow, carry_out, result}
  assign obs1 = {gt1, zero1, ovf1, cout1, result1};
  assign obs4 = {gt4, zero4, ovf4, cout4, result4};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_model(input logic [7:0] ma, input logic [7:0] mb,
                                            input logic [1:0] mop, input logic mai,
                                            input logic mbi, input logic mci);
    logic [8:0] s;
    logic [7:0] r;
    logic       co, ov;
    co = 1'b0;
    ov = 1'b0;
    s  = '0;
    case (mop)
      2'b00: begin
        s  = {1'b0, ma} + {1'b0, mb} + 9'(mci);
        r  = s[7:0];
        co = s[8];
        ov = (ma[7] == mb[7]) && (r[7] != ma[7]);
      end
      2'b01: begin
        s  = {1'b0, ma} + {1'b0, ~mb} + 9'(!mci);
        r  = s[7:0];
        co = s[8];
        ov = (ma[7] != mb[7]) && (r[7] != ma[7]);
      end
      2'b10:   r = (ma ^ {8{mai}}) & (mb ^ {8{mbi}});
      default: r = (ma ^ {8{mai}}) | (mb ^ {8{mbi}});
    endcase
    return {ma > mb, r == 8'h00, ov, co, r};
  endfunction

  // pre: request already driven with start=1; mid: pulse start with other operands in RUN;
  // handoff: raise start with the next request in the SLICES=1 done cycle and return.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                        input logic tai, input logic tbi, input logic tci,
                        input bit pre, input bit mid, input bit handoff,
                        input logic [7:0] na, input logic [7:0] nb, input logic [1:0] nop);
    logic [11:0] exp;
    int busy_n1, busy_n4, done_n1, done_n4, dc1, dc4;
    exp = ref_model(ta, tb_, top, tai, tbi, tci);
    if (!pre) begin
      a = ta; b = tb_; op = top; ainvert = tai; binvert = tbi; carry_in = tci; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    busy_n1 = 0; busy_n4 = 0; done_n1 = 0; done_n4 = 0; dc1 = 0; dc4 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) begin
        check_eq("busy1_rise", busy1, 1);
        check_eq("busy4_rise", busy4, 1);
      end
      check_eq("overlap1", busy1 & done1, 0);
      check_eq("overlap4", busy4 & done4, 0);
      if (busy1) busy_n1++;
      if (busy4) busy_n4++;
      if (done4) begin
        done_n4++; dc4 = c;
        check_eq("res4", obs4, exp);
      end
      if (done1) begin
        done_n1++; dc1 = c;
        check_eq("res1", obs1, exp);
        if (handoff) begin
          a = na; b = nb; op = nop; ainvert = 0; binvert = 0; carry_in = 0; start = 1'b1;
          break;
        end
      end
      if (mid && c == 2) begin
        start = 1'b1; a = ~ta; b = 8'h5A; op = 2'b10;
      end
      if (mid && c == 3) start = 1'b0;
      @(negedge clk);
    end
    check_eq("busy1_cycles", busy_n1, 8);
    check_eq("busy4_cycles", busy_n4, 2);
    check_eq("done1_count", done_n1, 1);
    check_eq("done4_count", done_n4, 1);
    check_eq("done1_latency", dc1, 9);
    check_eq("done4_latency", dc4, 3);
    if (!handoff) begin
      check_eq("hold1", obs1, exp);
      check_eq("hold4", obs4, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    ainvert = 0; binvert = 0; carry_in = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_done1", done1, 0);
    check_eq("rst_out1", obs1, 0);
    check_eq("rst_out4", obs4, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(8'h7F, 8'h01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_op(8'h05, 8'h05, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_op(8'h00, 8'h00, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    run_op(8'hF0, 8'h0F, 2'b10, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    run_op(8'hF0, 8'hFF, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // start pulsed mid-run must be ignored
    run_op(8'h3C, 8'hA5, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // back-to-back: next request accepted in the done cycle
    run_op(8'h80, 8'h80, 2'b00, 0, 0, 0, 0, 0, 1, 8'h12, 8'h34, 2'b01);
    run_op(8'h12, 8'h34, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Reset during the 4th RUN cycle aborts the operation
    a = 8'h55; b = 8'h22; op = 2'b00; carry_in = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy1", busy1, 0);
    check_eq("abort_done1", done1, 0);
    check_eq("abort_out1", obs1, 0);
    check_eq("abort_out4", obs4, 0);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'h01, 8'h01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 0, (n % 5) == 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
